fma_pipe_stage_elastic: RTL and testbench
=========================================

// Module: fma_pipe_stage_elastic
// PURPOSE
//  Parametrised elastic pipeline register between single-precision FMA stages
//  (product/addend alignment bundle: exp_P, sig_P, exp_C, sig_C, two_en).
//  Adds a valid/ready handshake, flush and a 2-entry skid buffer.
//  The skid buffer sustains full throughput under downstream back-pressure.
//  Drop-in between multiplier-tree, alignment and add/normalise stages.
// PARAMETERS
//  EXP_W   8   exponent width of exp_P / exp_C
//  SIG_W   50  significand width of sig_P / sig_C
//  FLAG_W  2   width of two_en (stage control flags)
// PORTS
//  clk         in   1       rising-edge clock
//  rst_n       in   1       asynchronous, active-low reset
//  flush       in   1       synchronous pipeline kill
//  in_valid    in   1       upstream bundle valid
//  in_ready    out  1       stage accepts bundle this cycle
//  exp_P_in    in   EXP_W   product exponent
//  sig_P_in    in   SIG_W   product significand
//  two_en_in   in   FLAG_W  control flags
//  exp_C_in    in   EXP_W   addend exponent
//  sig_C_in    in   SIG_W   addend significand
//  out_valid   out  1       output bundle valid
//  out_ready   in   1       downstream accepts
//  exp_P_out, sig_P_out, two_en_out, exp_C_out, sig_C_out  out  (same widths)  registered bundle
//  occupancy   out  2       entries held: 0, 1 or 2
// BEHAVIOUR
//  - in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
//  - Reset (rst_n=0, immediate, async): every output bundle field = 0, out_valid=0,
//    occupancy=0, skid register=0. in_ready=1 after reset is released.
//  - Latency 1 cycle: in_fire at edge n (stage empty) -> out_valid=1 with the data after edge n.
//  - out_valid=1 & out_ready=0 -> all *_out held bit-stable (no change).
//  - State = occupancy. Data goes to the main (output) register; the skid register
//    holds one overflow bundle.
//  - EMPTY(0): in_fire -> ONE, main<=in.
//  - ONE(1): in_fire&out_fire -> ONE, main<=in; in_fire only -> TWO, skid<=in.
//    out_fire only -> EMPTY.
//  - TWO(2): in_ready=0; out_fire -> ONE, main<=skid.
//  - in_ready is registered: in_ready = (occupancy!=2). It has no combinational path from out_ready.
//  - Ordering is strict FIFO. No bundle is dropped or duplicated except by flush.
//  - flush=1: after the edge, occupancy=0, out_valid=0 and in_ready=1.
//    Flush has priority over any in_fire/out_fire in the same cycle.
//    The in_fire bundle in that cycle is discarded; data registers keep their stale values.
//  - Deasserting rst_n mid-transfer discards all held bundles.
// CONFIGURATION
//  FMA_PIPE_SKID_EN defined: 2-entry skid behaviour as above.
//  FMA_PIPE_SKID_EN undefined: single register, no skid storage.
//    States are EMPTY/ONE only and occupancy never reaches 2.
//    in_ready = ~out_valid | out_ready (combinational).
//    ONE & in_fire & out_fire -> ONE, main<=in.
//    Reset and flush behaviour are the same in both builds.
// TESTING
//  1 Reset: rst_n=0 mid-stream with occupancy=2 -> outputs 0, out_valid=0 and occupancy=0
//    at once, with no clock edge needed.
//  2 Streaming: out_ready=1, 8 back-to-back bundles exp_P=8'h01..8'h08 -> outputs 1 cycle
//    later in order, in_ready stays 1, no bubbles.
//  3 Back-pressure: out_ready=0, send A (sig_P=50'h1), B (50'h2), C
//    -> occupancy=2, in_ready=0, C not accepted; out holds A.
//    Then out_ready=1 -> A, B, C in order, with no loss.
//  4 Flush: occupancy=2 and in_valid=1 with flush=1 -> next cycle occupancy=0, out_valid=0.
//    Neither held bundle nor the new bundle ever appears.
//  5 Stability: out_valid=1, out_ready=0 for 5 cycles while inputs toggle
//    -> sig_C_out and two_en_out unchanged.
//  6 Build without FMA_PIPE_SKID_EN: out_ready=0 -> in_ready=0 same cycle as out_valid=1,
//    occupancy<=1; stream test still shows no bubbles.

Source files
------------

// File: rtl/fma_pipe_stage_elastic.sv
// Elastic valid/ready register for the FMA alignment bundle; FMA_PIPE_SKID_EN adds a 2-entry skid path.
// Latency 1 cycle; flush kills held and incoming bundles. In the skid build in_ready is registered,
// otherwise in_ready = ~out_valid | out_ready.
module fma_pipe_stage_elastic #(
   parameter int EXP_W  = 8,
   parameter int SIG_W  = 50,
   parameter int FLAG_W = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [EXP_W-1:0]  exp_P_in,
   input  logic [SIG_W-1:0]  sig_P_in,
   input  logic [FLAG_W-1:0] two_en_in,
   input  logic [EXP_W-1:0]  exp_C_in,
   input  logic [SIG_W-1:0]  sig_C_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [EXP_W-1:0]  exp_P_out,
   output logic [SIG_W-1:0]  sig_P_out,
   output logic [FLAG_W-1:0] two_en_out,
   output logic [EXP_W-1:0]  exp_C_out,
   output logic [SIG_W-1:0]  sig_C_out,
   output logic [1:0]        occupancy
);

   typedef struct packed {
      logic [EXP_W-1:0]  exp_p;
      logic [SIG_W-1:0]  sig_p;
      logic [FLAG_W-1:0] two_en;
      logic [EXP_W-1:0]  exp_c;
      logic [SIG_W-1:0]  sig_c;
   } bundle_t;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t  state_q, state_d;
   bundle_t main_q, main_d;
   bundle_t in_bundle;
   logic    in_fire, out_fire;

   assign in_bundle = '{exp_p: exp_P_in, sig_p: sig_P_in, two_en: two_en_in,
                        exp_c: exp_C_in, sig_c: sig_C_in};

   assign out_valid  = (state_q != EMPTY);
   assign occupancy  = state_q;
   assign exp_P_out  = main_q.exp_p;
   assign sig_P_out  = main_q.sig_p;
   assign two_en_out = main_q.two_en;
   assign exp_C_out  = main_q.exp_c;
   assign sig_C_out  = main_q.sig_c;
   assign in_fire    = in_valid & in_ready;
   assign out_fire   = out_valid & out_ready;

`ifdef FMA_PIPE_SKID_EN
   bundle_t skid_q, skid_d;
   logic    in_ready_q, in_ready_d;

   // in_ready comes straight from a flop so out_ready never reaches upstream combinationally
   assign in_ready = in_ready_q;

   always_comb begin
      state_d    = state_q;
      main_d     = main_q;
      skid_d     = skid_q;
      if (flush) begin
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: if (in_fire) begin
               state_d = ONE;
               main_d  = in_bundle;
            end
            ONE: begin
               if (in_fire && out_fire) begin
                  main_d = in_bundle;
               end else if (in_fire) begin
                  state_d = TWO;
                  skid_d  = in_bundle;
               end else if (out_fire) begin
                  state_d = EMPTY;
               end
            end
            TWO: if (out_fire) begin
               state_d = ONE;
               main_d  = skid_q;
            end
            default: state_d = EMPTY;
         endcase
      end
      in_ready_d = (state_d != TWO);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= EMPTY;
         main_q     <= '0;
         skid_q     <= '0;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         main_q     <= main_d;
         skid_q     <= skid_d;
         in_ready_q <= in_ready_d;
      end
   end
`else
   assign in_ready = ~out_valid | out_ready;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      if (flush) begin
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: if (in_fire) begin
               state_d = ONE;
               main_d  = in_bundle;
            end
            // in ONE an accept implies a simultaneous drain, so the register just reloads
            ONE: begin
               if (in_fire) begin
                  main_d = in_bundle;
               end else if (out_fire) begin
                  state_d = EMPTY;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         main_q  <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
      end
   end
`endif

endmodule

// File: tb/tb_fma_pipe_stage_elastic.sv
// Scoreboard bench for fma_pipe_stage_elastic; expectations follow whichever build is compiled.
module tb_fma_pipe_stage_elastic;

   typedef struct packed {
      logic [7:0]  exp_p;
      logic [49:0] sig_p;
      logic [1:0]  two_en;
      logic [7:0]  exp_c;
      logic [49:0] sig_c;
   } bundle_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic        in_ready, out_valid;
   logic [1:0]  occupancy;
   bundle_t     cur = '0;
   bundle_t     out_b;
   logic [7:0]  exp_P_out, exp_C_out;
   logic [49:0] sig_P_out, sig_C_out;
   logic [1:0]  two_en_out;

   bundle_t     q[$];
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   assign out_b = {exp_P_out, sig_P_out, two_en_out, exp_C_out, sig_C_out};

   fma_pipe_stage_elastic dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .exp_P_in(cur.exp_p), .sig_P_in(cur.sig_p), .two_en_in(cur.two_en),
      .exp_C_in(cur.exp_c), .sig_C_in(cur.sig_c),
      .out_valid(out_valid), .out_ready(out_ready),
      .exp_P_out(exp_P_out), .sig_P_out(sig_P_out), .two_en_out(two_en_out),
      .exp_C_out(exp_C_out), .sig_C_out(sig_C_out),
      .occupancy(occupancy)
   );

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bundle_t mk(input logic [7:0] e, input logic [49:0] s);
      bundle_t b;
      b.exp_p  = e;
      b.sig_p  = s;
      b.two_en = e[1:0];
      b.exp_c  = ~e;
      b.sig_c  = ~s;
      return b;
   endfunction

   function automatic bundle_t rnd();
      logic [63:0] r;
      r = {$urandom, $urandom};
      return mk(r[57:50], r[49:0]);
   endfunction

   function automatic logic exp_ready();
`ifdef FMA_PIPE_SKID_EN
      return q.size() != 2;
`else
      return (q.size() == 0) || out_ready;
`endif
   endfunction

   // One clock: check outputs at the falling edge, then advance the model on the rising edge.
   task automatic cycle(output logic accepted);
      logic fi, fo;
      @(negedge clk);
      chk("out_valid", 128'(out_valid), 128'(q.size() > 0));
      chk("occupancy", 128'(occupancy), 128'(q.size()));
      chk("in_ready", 128'(in_ready), 128'(exp_ready()));
      if (q.size() > 0) chk("out_data", 128'(out_b), 128'(q[0]));
      fi = in_valid && exp_ready();
      fo = (q.size() > 0) && out_ready;
      @(posedge clk);
      accepted = fi && !flush;
      if (flush) begin
         q.delete();
      end else begin
         if (fo) void'(q.pop_front());
         if (fi) q.push_back(cur);
      end
      #1;
   endtask

   task automatic send(input bundle_t b);
      logic acc;
      cur = b;
      in_valid = 1'b1;
      cycle(acc);
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      logic acc;
      for (int i = 0; i < n; i++) cycle(acc);
   endtask

   initial begin
      logic acc;
      #1 rst_n = 1'b0;
      #1;
      chk("rst_valid", 128'(out_valid), 128'(0));
      chk("rst_occ", 128'(occupancy), 128'(0));
      chk("rst_data", 128'(out_b), 128'(0));
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      idle(1);

      // streaming, no bubbles
      out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) send(mk(8'(i), 50'(i * 3)));
      idle(2);

      // back-pressure: A, B, then C retried until accepted
      out_ready = 1'b0;
      send(mk(8'h0A, 50'h1));
      send(mk(8'h0B, 50'h2));
      cur = mk(8'h0C, 50'h3);
      in_valid = 1'b1;
      idle(2);
      out_ready = 1'b1;
      for (int n = 0; n < 6; n++) begin
         cycle(acc);
         if (acc) break;
      end
      in_valid = 1'b0;
      idle(4);

      // flush with full stage and a new bundle offered
      out_ready = 1'b0;
      send(mk(8'h21, 50'h21));
      send(mk(8'h22, 50'h22));
      cur = mk(8'h23, 50'h23);
      in_valid = 1'b1;
      flush = 1'b1;
      cycle(acc);
      flush = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      idle(3);

      // output stability under back-pressure while inputs toggle
      out_ready = 1'b0;
      send(mk(8'h31, 50'h3_1234_5678));
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cur = rnd();
         cycle(acc);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      idle(4);

      // asynchronous reset with bundles held
      out_ready = 1'b0;
      send(mk(8'h41, 50'h41));
      send(mk(8'h42, 50'h42));
      #3 rst_n = 1'b0;
      #1;
      chk("arst_valid", 128'(out_valid), 128'(0));
      chk("arst_occ", 128'(occupancy), 128'(0));
      chk("arst_data", 128'(out_b), 128'(0));
      q.delete();
      @(posedge clk);
      #1 rst_n = 1'b1;
      idle(1);

      // random traffic with occasional flush
      for (int i = 0; i < 80; i++) begin
         cur = rnd();
         in_valid = 1'($urandom_range(0, 3) != 0);
         out_ready = 1'($urandom_range(0, 2) != 0);
         flush = ($urandom_range(0, 15) == 0);
         cycle(acc);
      end
      flush = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      idle(4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
